// File: rtl/maze_pkg.sv
// Shared types, constants and the LFSR step function for the maze generator.
package maze_pkg;

   typedef enum logic [1:0] {INIT, CARVE, TRACE, DONE} state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Galois right shift: feed the dropped lsb back through the tap mask
   function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step; load has priority.
module maze_lfsr16
   import maze_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= LFSR_SEED;
      else if (load)
         state <= load_val;
      else if (step)
         state <= lfsr16_step(state);
   end

endmodule

// File: rtl/maze_gen.sv
// Binary-tree maze generator, one cell-row per cycle, with optional solution
// tracing enabled by defining MAZEGEN_PATH_EN.
module maze_gen
   import maze_pkg::*;
#(
   parameter int size = 17
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [15:0]     seed,
   output logic            done,
   output logic [size-1:0] maze       [size-1:0],
   output logic [size-1:0] ideal_path [size-1:0]
);

   localparam int N  = (size - 1) / 2;
   localparam int CW = $clog2(size);
   localparam logic [CW-1:0] FIRST = CW'(1);
   localparam logic [CW-1:0] LAST  = CW'(size - 2);

   state_t        state, state_nx;
   logic [CW-1:0] carve_r;
   logic [15:0]   lfsr;
   logic          lfsr_load, lfsr_step;
   logic          lfsr_unused;

   // only the low N bits drive carving decisions
   assign lfsr_unused = ^(lfsr >> N);

   maze_lfsr16 u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lfsr_load),
      .load_val ((seed == 16'h0000) ? LFSR_SEED : seed),
      .step     (lfsr_step),
      .state    (lfsr)
   );

`ifdef MAZEGEN_PATH_EN
   logic          started, go_north, trace_last;
   logic [CW-1:0] pos_r, pos_c, nx_r, nx_c, wall_r, wall_c;

   always_comb begin
      go_north = 1'b0;
      if (pos_r != FIRST) begin
         if (pos_c == LAST) go_north = 1'b1;
         else               go_north = !maze[pos_r - FIRST][pos_c];
      end
      nx_r       = go_north ? pos_r - CW'(2) : pos_r;
      nx_c       = go_north ? pos_c : pos_c + CW'(2);
      wall_r     = go_north ? pos_r - FIRST : pos_r;
      wall_c     = go_north ? pos_c : pos_c + FIRST;
      trace_last = started && (nx_r == FIRST) && (nx_c == LAST);
   end
`endif

   always_comb begin
      state_nx  = state;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state)
         INIT: begin
            lfsr_load = 1'b1;
            state_nx  = CARVE;
         end
         CARVE: begin
            lfsr_step = 1'b1;
`ifdef MAZEGEN_PATH_EN
            if (carve_r == LAST) state_nx = TRACE;
`else
            if (carve_r == LAST) state_nx = DONE;
`endif
         end
`ifdef MAZEGEN_PATH_EN
         TRACE: if (trace_last) state_nx = DONE;
`endif
         DONE:    state_nx = DONE;
         default: state_nx = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= INIT;
      else        state <= state_nx;
   end

   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               carve_r <= FIRST;
      else if (state == INIT)   carve_r <= FIRST;
      else if (state == CARVE)  carve_r <= carve_r + CW'(2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < size; r++) maze[r] <= '1;
      end else begin
         case (state)
            INIT: begin
               for (int unsigned i = 0; i < N; i++)
                  for (int unsigned j = 0; j < N; j++)
                     maze[2*i+1][2*j+1] <= 1'b0;
               maze[size-2][0] <= 1'b0;
               maze[1][size-1] <= 1'b0;
            end
            CARVE: begin
               // row 0 always goes east, column N-1 always north, else a coin flip
               for (int unsigned j = 0; j < N; j++) begin
                  if (carve_r == FIRST) begin
                     if (j < N - 1) maze[carve_r][2*j+2] <= 1'b0;
                  end else if (j == N - 1) begin
                     maze[carve_r - FIRST][2*j+1] <= 1'b0;
                  end else if (lfsr[j]) begin
                     maze[carve_r][2*j+2] <= 1'b0;
                  end else begin
                     maze[carve_r - FIRST][2*j+1] <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MAZEGEN_PATH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         pos_r   <= LAST;
         pos_c   <= FIRST;
         for (int unsigned r = 0; r < size; r++) ideal_path[r] <= '0;
      end else if (state == TRACE) begin
         if (!started) begin
            started                <= 1'b1;
            ideal_path[size-2][0]  <= 1'b1;
            ideal_path[size-2][1]  <= 1'b1;
         end else begin
            pos_r                  <= nx_r;
            pos_c                  <= nx_c;
            ideal_path[wall_r][wall_c] <= 1'b1;
            ideal_path[nx_r][nx_c]     <= 1'b1;
            if (trace_last) ideal_path[1][size-1] <= 1'b1;
         end
      end
   end
`else
   always_comb begin
      for (int unsigned r = 0; r < size; r++) ideal_path[r] = '0;
   end
`endif

endmodule

// File: tb/tb_maze_gen.sv
// Directed bench for maze_gen (size=17); expectations follow MAZEGEN_PATH_EN.
module tb_maze_gen;

   localparam int SZ = 17;
   localparam int N  = 8;
`ifdef MAZEGEN_PATH_EN
   localparam int DONE_EDGE = 3 * N;
`else
   localparam int DONE_EDGE = N + 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   seed = 16'h1234;
   logic          done;
   logic [SZ-1:0] maze  [SZ-1:0];
   logic [SZ-1:0] ideal [SZ-1:0];
   logic [SZ-1:0] exp_m [SZ-1:0];
   logic [SZ-1:0] ref_m [SZ-1:0];
   logic [SZ-1:0] ref_p [SZ-1:0];
   logic [SZ-1:0] tmp_m [SZ-1:0];

   int n_checks = 0;
   int n_fail   = 0;
   int de;

   maze_gen #(.size(SZ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed       (seed),
      .done       (done),
      .maze       (maze),
      .ideal_path (ideal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // kind: 0 any, 1 cell (odd/odd), 2 post (even/even), 3 wall (mixed parity)
   function automatic int count(input bit path, input int kind, input int r0, input int r1,
                                input int c0, input int c1, input bit val);
      int n = 0;
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++) begin
            bit k;
            case (kind)
               1:       k = (r % 2 == 1) && (c % 2 == 1);
               2:       k = (r % 2 == 0) && (c % 2 == 0);
               3:       k = (r % 2) != (c % 2);
               default: k = 1'b1;
            endcase
            if (k && ((path ? ideal[r][c] : maze[r][c]) == val)) n++;
         end
      return n;
   endfunction

   function automatic int border_ones();
      int n = 0;
      for (int r = 0; r < SZ; r++)
         for (int c = 0; c < SZ; c++)
            if ((r == 0 || r == SZ-1 || c == 0 || c == SZ-1) && maze[r][c]) n++;
      return n;
   endfunction

   function automatic int path_on_wall();
      int n = 0;
      for (int r = 0; r < SZ; r++)
         for (int c = 0; c < SZ; c++)
            if (ideal[r][c] && maze[r][c]) n++;
      return n;
   endfunction

   // walk the path bits from the entrance; returns steps to the exit or -1
   function automatic int chain_len();
      bit vis [SZ][SZ];
      int r = SZ-2, c = 0, steps = 0;
      int dr [4] = '{-1, 1, 0, 0};
      int dc [4] = '{0, 0, -1, 1};
      for (int a = 0; a < SZ; a++) for (int b = 0; b < SZ; b++) vis[a][b] = 1'b0;
      if (!ideal[r][c]) return -1;
      vis[r][c] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         bit found = 1'b0;
         if (r == 1 && c == SZ-1) return steps;
         for (int d = 0; d < 4; d++) begin
            int nr = r + dr[d];
            int nc = c + dc[d];
            if (!found && nr >= 0 && nr < SZ && nc >= 0 && nc < SZ && ideal[nr][nc] && !vis[nr][nc]) begin
               found = 1'b1; r = nr; c = nc; vis[nr][nc] = 1'b1; steps++;
            end
         end
         if (!found) return -1;
      end
      return -1;
   endfunction

   task automatic model(input logic [15:0] sd);
      logic [15:0] s;
      s = (sd == 16'h0) ? 16'hACE1 : sd;
      for (int r = 0; r < SZ; r++) exp_m[r] = '1;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) exp_m[2*i+1][2*j+1] = 1'b0;
      exp_m[SZ-2][0] = 1'b0;
      exp_m[1][SZ-1] = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            bit east;
            if (i == 0)          east = (j < N-1);
            else if (j == N-1)   east = 1'b0;
            else                 east = s[j];
            if (east && !(i == 0 && j == N-1)) exp_m[2*i+1][2*j+2] = 1'b0;
            else if (i > 0)                    exp_m[2*i][2*j+1]   = 1'b0;
         end
         s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      end
   endtask

   function automatic int diff_exp();
      int n = 0;
      for (int r = 0; r < SZ; r++) if (maze[r] != exp_m[r]) n++;
      return n;
   endfunction

   function automatic int diff_ref(input bit path);
      int n = 0;
      for (int r = 0; r < SZ; r++)
         if (path ? (ideal[r] != ref_p[r]) : (maze[r] != ref_m[r])) n++;
      return n;
   endfunction

   function automatic int diff_tmp();
      int n = 0;
      for (int r = 0; r < SZ; r++) if (maze[r] != tmp_m[r]) n++;
      return n;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // release reset, count edges until done; seed is scrambled after INIT
   task automatic run(input logic [15:0] sd, output int done_edge);
      seed = sd;
      @(negedge clk);
      rst_n = 1'b1;
      done_edge = 0;
      for (int e = 1; e <= 40 && done_edge == 0; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) seed = ~sd;
         if (done) done_edge = e;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", done, 0);
      check("rst_maze_ones", count(0, 0, 0, SZ-1, 0, SZ-1, 1'b1), SZ*SZ);
      check("rst_path_ones", count(1, 0, 0, SZ-1, 0, SZ-1, 1'b1), 0);

      run(16'h1234, de);
      check("done_edge_1234", de, DONE_EDGE);
      check("entrance_open", maze[SZ-2][0], 0);
      check("exit_open", maze[1][SZ-1], 0);
      check("border_ones", border_ones(), 4*SZ-4-2);
      check("cells_open", count(0, 1, 0, SZ-1, 0, SZ-1, 1'b1), 0);
      check("posts_closed", count(0, 2, 0, SZ-1, 0, SZ-1, 1'b1), (N+1)*(N+1));
      check("row1_open", count(0, 0, 1, 1, 1, SZ-2, 1'b1), 0);
      check("col_east_open", count(0, 0, 1, SZ-2, SZ-2, SZ-2, 1'b1), 0);
      check("walls_open", count(0, 3, 1, SZ-2, 1, SZ-2, 1'b0), N*N-1);
      // row 1 of 0x1234 uses 0x091A: cell(1,0) bit0=0 north, cell(1,1) bit1=1 east
      check("hand_n_1_0", maze[2][1], 0);
      check("hand_e_1_0", maze[3][2], 1);
      check("hand_e_1_1", maze[3][4], 0);
      check("hand_n_1_1", maze[2][3], 1);
      model(16'h1234);
      check("model_1234", diff_exp(), 0);
`ifdef MAZEGEN_PATH_EN
      check("path_bits", count(1, 0, 0, SZ-1, 0, SZ-1, 1'b1), 4*N-1);
      check("path_cells", count(1, 1, 0, SZ-1, 0, SZ-1, 1'b1), 2*N-1);
      check("path_walls", count(1, 3, 1, SZ-2, 1, SZ-2, 1'b1), 2*N-2);
      check("path_on_wall", path_on_wall(), 0);
      check("path_chain", chain_len(), 4*N-2);
`else
      check("path_zero", count(1, 0, 0, SZ-1, 0, SZ-1, 1'b1), 0);
`endif
      for (int r = 0; r < SZ; r++) begin ref_m[r] = maze[r]; ref_p[r] = ideal[r]; end
      repeat (5) @(posedge clk);
      #1;
      check("done_held", done, 1);
      check("frozen", diff_ref(1'b0) + diff_ref(1'b1), 0);

      do_reset();
      run(16'h1234, de);
      check("done_edge_rerun", de, DONE_EDGE);
      check("rerun_maze", diff_ref(1'b0), 0);
      check("rerun_path", diff_ref(1'b1), 0);

      do_reset();
      run(16'h0000, de);
      check("done_edge_seed0", de, DONE_EDGE);
      model(16'hACE1);
      check("model_seed0", diff_exp(), 0);
      for (int r = 0; r < SZ; r++) tmp_m[r] = maze[r];
      do_reset();
      run(16'hACE1, de);
      check("seed0_vs_ace1", diff_tmp(), 0);

      do_reset();
      run(16'h4321, de);
      check("seed_differs", (diff_ref(1'b0) != 0) ? 1 : 0, 1);

      do_reset();
      seed = 16'h1234;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_done", done, 0);
      check("mid_rst_maze", count(0, 0, 0, SZ-1, 0, SZ-1, 1'b1), SZ*SZ);
      check("mid_rst_path", count(1, 0, 0, SZ-1, 0, SZ-1, 1'b1), 0);
      run(16'h1234, de);
      check("done_edge_after_mid", de, DONE_EDGE);
      check("after_mid_maze", diff_ref(1'b0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
